// File: rtl/jt89_pkg.sv
// JT89 CPU write port: sound register indices, reset constants and shared types.
// The register file is one packed struct so it resets and updates as a single value.
package jt89_pkg;

  localparam logic [2:0] TONE0 = 3'd0;
  localparam logic [2:0] VOL0  = 3'd1;
  localparam logic [2:0] TONE1 = 3'd2;
  localparam logic [2:0] VOL1  = 3'd3;
  localparam logic [2:0] TONE2 = 3'd4;
  localparam logic [2:0] VOL2  = 3'd5;
  localparam logic [2:0] NOISE = 3'd6;
  localparam logic [2:0] VOL3  = 3'd7;

  localparam logic [3:0] VOL_SILENT = 4'hF;

  typedef struct packed {
    logic [2:0][9:0] tone;
    logic [3:0][3:0] vol;
    logic [2:0]      ctrl3;
  } regs_t;

  localparam regs_t      REGS_RST  = '{tone: '0, vol: {4{VOL_SILENT}}, ctrl3: 3'd0};
  localparam logic [2:0] LATCH_RST = TONE0;

  typedef enum logic {ST_IDLE, ST_BUSY} rdy_state_t;

  // Channel number is the upper two bits of the register index.
  function automatic logic [1:0] chan_of(input logic [2:0] idx);
    return idx[2:1];
  endfunction

endpackage

// File: rtl/jt89_if.sv
// CPU-side bus of the PSG: data byte, active-low select/strobe, READY back to the CPU.
interface jt89_if;
  logic [7:0] din;
  logic       cs_n;
  logic       wr_n;
  logic       ready;

  modport master (output din, cs_n, wr_n, input ready);
  modport slave  (input din, cs_n, wr_n, output ready);
endinterface

// File: rtl/jt89_ready.sv
// READY handshake: drops 1 clk after an accepted write, stays low for BUSY_TICKS clk_en ticks.
// A clk_en in the accepting cycle is not counted because the FSM is still IDLE then.
module jt89_ready
  import jt89_pkg::*;
#(
  parameter int BUSY_TICKS = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clk_en,
  input  logic i_accept,
  output logic o_ready
);

  rdy_state_t r_state, w_state_nxt;
  logic [7:0] r_cnt, w_cnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    o_ready     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_ready = 1'b1;
        if (i_accept) begin
          w_state_nxt = ST_BUSY;
          w_cnt_nxt   = 8'(BUSY_TICKS);
        end
      end
      ST_BUSY: begin
        if (i_clk_en) begin
          if (r_cnt == 8'd1) w_state_nxt = ST_IDLE;
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
    endcase
  end

endmodule

// File: rtl/jt89_cpu_if.sv
// SN76489-style write port: decodes latch/data bytes into the eight sound registers.
// Registers update 1 clk after acceptance; writes are ignored while READY is low.
module jt89_cpu_if
  import jt89_pkg::*;
#(
  parameter int BUSY_TICKS = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clk_en,
  jt89_if.slave      bus,
  output logic [9:0] o_tone0,
  output logic [9:0] o_tone1,
  output logic [9:0] o_tone2,
  output logic [3:0] o_vol0,
  output logic [3:0] o_vol1,
  output logic [3:0] o_vol2,
  output logic [3:0] o_vol3,
  output logic [2:0] o_ctrl3,
  output logic       o_clr
);

  logic       r_wr_l;
  logic [2:0] r_latch;
  regs_t      r_regs, w_regs_nxt;
  logic       r_clr;
  logic       w_ready;
  logic       w_accept;
  logic [2:0] w_idx;
  logic [1:0] w_ch;

  // Only a fresh falling edge of wr_n counts, so a strobe held low through busy is ignored.
  assign w_accept = !bus.cs_n && !bus.wr_n && r_wr_l && w_ready;
  assign w_idx    = bus.din[7] ? bus.din[6:4] : r_latch;
  assign w_ch     = chan_of(w_idx);

  always_comb begin
    w_regs_nxt = r_regs;
    case (w_idx)
      TONE0, TONE1, TONE2: begin
        if (bus.din[7]) w_regs_nxt.tone[w_ch][3:0] = bus.din[3:0];
        else            w_regs_nxt.tone[w_ch][9:4] = bus.din[5:0];
      end
      VOL0, VOL1, VOL2, VOL3: w_regs_nxt.vol[w_ch] = bus.din[3:0];
      NOISE:                  w_regs_nxt.ctrl3     = bus.din[2:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_l  <= 1'b1;
      r_latch <= LATCH_RST;
      r_regs  <= REGS_RST;
      r_clr   <= 1'b0;
    end else begin
      r_wr_l <= bus.wr_n;
      r_clr  <= w_accept && (w_idx == NOISE);
      if (w_accept) begin
        r_regs <= w_regs_nxt;
        if (bus.din[7]) r_latch <= bus.din[6:4];
      end
    end
  end

  jt89_ready #(.BUSY_TICKS(BUSY_TICKS)) u_ready (
    .clk      (clk),
    .rst      (rst),
    .i_clk_en (i_clk_en),
    .i_accept (w_accept),
    .o_ready  (w_ready)
  );

  assign bus.ready = w_ready;
  assign o_tone0   = r_regs.tone[0];
  assign o_tone1   = r_regs.tone[1];
  assign o_tone2   = r_regs.tone[2];
  assign o_vol0    = r_regs.vol[0];
  assign o_vol1    = r_regs.vol[1];
  assign o_vol2    = r_regs.vol[2];
  assign o_vol3    = r_regs.vol[3];
  assign o_ctrl3   = r_regs.ctrl3;
  assign o_clr     = r_clr;

endmodule

// File: tb/tb_jt89_cpu_if.sv
// Bench for jt89_cpu_if: directed scenarios plus a random bus run against a behavioural model.
module tb_jt89_cpu_if;
  import jt89_pkg::*;

  localparam int BT = 32;

  logic       clk;
  logic       rst;
  logic       clk_en;
  logic [9:0] tone[3];
  logic [3:0] vol[4];
  logic [2:0] ctrl3;
  logic       clr;

  jt89_if bus();

  jt89_cpu_if #(.BUSY_TICKS(BT)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_clk_en (clk_en),
    .bus      (bus),
    .o_tone0  (tone[0]),
    .o_tone1  (tone[1]),
    .o_tone2  (tone[2]),
    .o_vol0   (vol[0]),
    .o_vol1   (vol[1]),
    .o_vol2   (vol[2]),
    .o_vol3   (vol[3]),
    .o_ctrl3  (ctrl3),
    .o_clr    (clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int unsigned en_pct = 100;

  // Behavioural model: register contents, latched index, ticks of busy time still owed.
  logic [9:0] m_tone[3];
  logic [3:0] m_vol[4];
  logic [2:0] m_ctrl;
  logic [2:0] m_idx;
  logic       m_clr;
  logic       m_prev_wr_n;
  int         m_left;

  task automatic m_reset();
    for (int i = 0; i < 3; i++) m_tone[i] = 10'd0;
    for (int i = 0; i < 4; i++) m_vol[i] = VOL_SILENT;
    m_ctrl = 3'd0;
    m_idx = 3'd0;
    m_clr = 1'b0;
    m_prev_wr_n = 1'b1;
    m_left = 0;
  endtask

  task automatic m_apply(input logic [7:0] d);
    int tgt;
    if (d[7]) m_idx = d[6:4];
    tgt = int'(m_idx);
    if (tgt == 6) begin
      m_ctrl = d[2:0];
      m_clr = 1'b1;
    end else if (tgt % 2 == 1) begin
      m_vol[tgt / 2] = d[3:0];
    end else if (d[7]) begin
      m_tone[tgt / 2] = (m_tone[tgt / 2] & 10'h3F0) | 10'(d[3:0]);
    end else begin
      m_tone[tgt / 2] = (m_tone[tgt / 2] & 10'h00F) | (10'(d[5:0]) << 4);
    end
  endtask

  // Pick this cycle's clk_en, advance the model over the coming edge, then pass the edge.
  task automatic step();
    logic acc;
    clk_en = ($urandom_range(0, 99) < en_pct);
    acc = !rst && !bus.cs_n && !bus.wr_n && m_prev_wr_n && (m_left == 0);
    m_clr = 1'b0;
    if (rst) begin
      m_reset();
    end else begin
      if (m_left > 0 && clk_en) m_left--;
      if (acc) begin
        m_apply(bus.din);
        m_left = BT;
      end
    end
    m_prev_wr_n = rst ? 1'b1 : bus.wr_n;
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] d);
    bus.din = d;
    bus.cs_n = 1'b0;
    bus.wr_n = 1'b0;
    step();
    bus.wr_n = 1'b1;
    bus.cs_n = 1'b1;
  endtask

  task automatic wait_idle(output int ticks);
    ticks = 0;
    for (int i = 0; i < 4000 && bus.ready !== 1'b1; i++) begin
      step();
      if (clk_en) ticks++;
    end
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    for (int i = 0; i < cycles; i++) step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(2);
    n_cmp++;
    if (bus.ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", bus.ready); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (vol[i] !== 4'hF) begin n_err++; $display("FAIL reset_vol%0d: got %h want f", i, vol[i]); end
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (tone[i] !== 10'd0) begin n_err++; $display("FAIL reset_tone%0d: got %h want 0", i, tone[i]); end
    end
    n_cmp++;
    if (ctrl3 !== 3'd0 || clr !== 1'b0) begin
      n_err++; $display("FAIL reset_noise: got ctrl3=%h clr=%b want 0/0", ctrl3, clr);
    end
  endtask

  task automatic test_tone();
    int ticks;
    en_pct = 50;
    write_byte(8'h8A);
    n_cmp++;
    if (bus.ready !== 1'b0) begin n_err++; $display("FAIL tone_ready_fall: got %b want 0", bus.ready); end
    n_cmp++;
    if (tone[0] !== 10'h00A) begin n_err++; $display("FAIL tone_latch: got %h want 00a", tone[0]); end
    wait_idle(ticks);
    n_cmp++;
    if (ticks !== BT) begin n_err++; $display("FAIL tone_busy1: got %0d ticks want %0d", ticks, BT); end
    write_byte(8'h3F);
    n_cmp++;
    if (tone[0] !== 10'h3FA) begin n_err++; $display("FAIL tone_data: got %h want 3fa", tone[0]); end
    wait_idle(ticks);
    n_cmp++;
    if (ticks !== BT) begin n_err++; $display("FAIL tone_busy2: got %0d ticks want %0d", ticks, BT); end
  endtask

  task automatic test_noise();
    int ticks;
    write_byte(8'hE5);
    n_cmp++;
    if (ctrl3 !== 3'b101 || clr !== 1'b1) begin
      n_err++; $display("FAIL noise_latch: got ctrl3=%b clr=%b want 101/1", ctrl3, clr);
    end
    step();
    n_cmp++;
    if (clr !== 1'b0) begin n_err++; $display("FAIL noise_clr_width: got %b want 0", clr); end
    wait_idle(ticks);
    write_byte(8'h02);
    n_cmp++;
    if (ctrl3 !== 3'b010 || clr !== 1'b1) begin
      n_err++; $display("FAIL noise_data: got ctrl3=%b clr=%b want 010/1", ctrl3, clr);
    end
    step();
    n_cmp++;
    if (clr !== 1'b0) begin n_err++; $display("FAIL noise_clr2_width: got %b want 0", clr); end
    wait_idle(ticks);
  endtask

  task automatic test_volume();
    int ticks;
    write_byte(8'hD3);
    n_cmp++;
    if (vol[2] !== 4'h3) begin n_err++; $display("FAIL vol_latch: got %h want 3", vol[2]); end
    wait_idle(ticks);
    write_byte(8'h07);
    n_cmp++;
    if (vol[2] !== 4'h7) begin n_err++; $display("FAIL vol_data: got %h want 7", vol[2]); end
    wait_idle(ticks);
    write_byte(8'h0C);
    n_cmp++;
    if (vol[2] !== 4'hC || tone[0] !== m_tone[0]) begin
      n_err++; $display("FAIL vol_relatch: got vol2=%h tone0=%h want c/%h", vol[2], tone[0], m_tone[0]);
    end
    wait_idle(ticks);
  endtask

  task automatic test_busy_reject();
    int ticks;
    do_reset(2);
    write_byte(8'h81);
    step();
    bus.din = 8'h9F;
    bus.cs_n = 1'b0;
    bus.wr_n = 1'b0;
    step();
    bus.wr_n = 1'b1;
    bus.cs_n = 1'b1;
    step();
    n_cmp++;
    if (bus.ready !== 1'b0 || vol[0] !== 4'hF) begin
      n_err++; $display("FAIL busy_reject: got ready=%b vol0=%h want 0/f", bus.ready, vol[0]);
    end
    wait_idle(ticks);
    n_cmp++;
    if (vol[0] !== 4'hF) begin n_err++; $display("FAIL busy_reject_after: got %h want f", vol[0]); end
  endtask

  task automatic test_hold_low();
    int ticks;
    bus.din = 8'h95;
    bus.cs_n = 1'b0;
    bus.wr_n = 1'b0;
    step();
    n_cmp++;
    if (vol[0] !== 4'h5) begin n_err++; $display("FAIL hold_first: got %h want 5", vol[0]); end
    bus.din = 8'h9A;
    wait_idle(ticks);
    for (int i = 0; i < 5; i++) step();
    n_cmp++;
    if (vol[0] !== 4'h5 || bus.ready !== 1'b1) begin
      n_err++; $display("FAIL hold_low: got vol0=%h ready=%b want 5/1", vol[0], bus.ready);
    end
    bus.wr_n = 1'b1;
    bus.cs_n = 1'b1;
    step();
    write_byte(8'h9A);
    n_cmp++;
    if (vol[0] !== 4'hA) begin n_err++; $display("FAIL hold_fresh: got %h want a", vol[0]); end
    wait_idle(ticks);
  endtask

  task automatic test_reset_midbusy();
    int ticks;
    en_pct = 50;
    write_byte(8'h81);
    ticks = 0;
    for (int i = 0; i < 1000 && ticks < 5; i++) begin
      step();
      if (clk_en) ticks++;
    end
    n_cmp++;
    if (bus.ready !== 1'b0 || ticks !== 5) begin
      n_err++; $display("FAIL midbusy_pre: got ready=%b ticks=%0d want 0/5", bus.ready, ticks);
    end
    rst = 1'b1;
    bus.din = 8'h9C;
    bus.cs_n = 1'b0;
    bus.wr_n = 1'b0;
    step();
    rst = 1'b0;
    bus.wr_n = 1'b1;
    bus.cs_n = 1'b1;
    n_cmp++;
    if (bus.ready !== 1'b1 || tone[0] !== 10'd0 || vol[0] !== 4'hF) begin
      n_err++; $display("FAIL midbusy_rst: got ready=%b tone0=%h vol0=%h want 1/0/f", bus.ready, tone[0], vol[0]);
    end
    write_byte(8'h84);
    n_cmp++;
    if (bus.ready !== 1'b0 || tone[0] !== 10'h004) begin
      n_err++; $display("FAIL midbusy_rewrite: got ready=%b tone0=%h want 0/004", bus.ready, tone[0]);
    end
    wait_idle(ticks);
  endtask

  task automatic test_random();
    logic [50:0] got;
    logic [50:0] exp;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 500 == 0) en_pct = $urandom_range(20, 100);
      rst = ($urandom_range(0, 299) == 0);
      if (bus.wr_n == 1'b0) begin
        if ($urandom_range(0, 1) == 0) bus.wr_n = 1'b1;
        if ($urandom_range(0, 3) == 0) bus.cs_n = ~bus.cs_n;
      end else if ($urandom_range(0, 5) == 0) begin
        bus.din = 8'($urandom);
        bus.cs_n = ($urandom_range(0, 5) == 0);
        bus.wr_n = 1'b0;
      end
      step();
      got = {bus.ready, clr, ctrl3, tone[0], tone[1], tone[2], vol[0], vol[1], vol[2], vol[3]};
      exp = {m_left == 0, m_clr, m_ctrl, m_tone[0], m_tone[1], m_tone[2],
             m_vol[0], m_vol[1], m_vol[2], m_vol[3]};
      n_cmp++;
      if (got !== exp) begin
        n_err++; $display("FAIL random_cyc%0d: got %h want %h", cyc, got, exp);
      end
    end
    rst = 1'b0;
    bus.wr_n = 1'b1;
    bus.cs_n = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    clk_en = 1'b0;
    bus.din = 8'h00;
    bus.cs_n = 1'b1;
    bus.wr_n = 1'b1;
    m_reset();
    #1;
    test_reset();
    test_tone();
    test_noise();
    test_volume();
    test_busy_reject();
    test_hold_low();
    test_reset_midbusy();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/jt89_cpu_if.md
# jt89_cpu_if

CPU-side write port of the JT89 PSG. Accepts SN76489-format byte writes, decodes latch/data bytes into the eight sound registers, and drives the READY handshake back to the CPU. Outputs feed the tone channels (10-bit periods), the noise block (ctrl3, clr) and all four volume attenuators.

## Interface
Parameters:
- BUSY_TICKS, 32: clk_en ticks READY stays low after an accepted write (range 1..255).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- clk_en  in  1  chip clock enable; paces the busy counter only
- din  in  8  CPU data byte
- cs_n  in  1  chip select, active-low
- wr_n  in  1  write strobe, active-low
- ready  out  1  high = chip can take a write
- tone0, tone1, tone2  out  10 each  tone period registers
- vol0, vol1, vol2, vol3  out  4 each  attenuation (F = silent)
- ctrl3  out  3  noise control: bit2 white/periodic, bits1:0 rate
- clr  out  1  one-clk pulse on every write to the noise control register

## Operation
- Write detect: wr_n registered into wr_l each clk. Accept when cs_n==0, wr_n==0, wr_l==1 and ready==1. Acceptance is evaluated on every clk, independent of clk_en.
- A falling edge while ready==0 is discarded; holding wr_n low through the end of busy does not trigger a write. Only a fresh falling edge does.
- Latch byte, din[7]==1: latch index <= din[6:4] (chan = din[6:5], type = din[4], 1 = volume). Data nibble din[3:0] goes to the target immediately:
  - tone n: period[3:0]
  - volume n: vol[3:0]
  - noise ctrl (index 6): ctrl3 <= din[2:0]
- Data byte, din[7]==0: applied to the currently latched index.
  - tone n: period[9:4] <= din[5:0]
  - volume: vol <= din[3:0]
  - noise ctrl: ctrl3 <= din[2:0]
- Latch index is unchanged by data bytes.
- clr: asserted for exactly one clk, the clk after an accepted write that targets index 6, whether latch or data byte.
- READY state machine:
  - IDLE: ready=1. On an accepted write go to BUSY and load cnt <= BUSY_TICKS.
  - BUSY: ready=0. On each clk_en, cnt decrements. When cnt is 1 and clk_en fires, return to IDLE.
  - Counter is 8 bits.

## Timing
- Reset values:
  - tone0..2 = 0, vol0..3 = 4'hF, ctrl3 = 0
  - latch index = 0 (tone0)
  - ready = 1, clr = 0
  - wr_l = 1, state IDLE
- Register outputs update on the clk edge after the accepting edge (latency 1 clk). clr and the ctrl3 update appear in the same cycle.
- ready falls 1 clk after acceptance. It rises on the clk following the BUSY_TICKS-th clk_en after acceptance.
- A clk_en coinciding with the acceptance cycle does not count.
- rst mid-busy: immediately returns to IDLE with ready=1 and all registers at reset values. A write pending in the same cycle as rst is dropped.
- Simultaneous rst and accept: rst wins.
- cs_n rising while wr_n is low: no effect after acceptance.

## Structure
- Shared package jt89_pkg holds:
  - register index localparams: TONE0=0, VOL0=1, TONE1=2, VOL1=3, TONE2=4, VOL2=5, NOISE=6, VOL3=7
  - VOL_SILENT = 4'hF
  - reset constants for the register file
- Natural sub-module: jt89_ready, holding the IDLE/BUSY FSM and the busy counter. Inputs: accept, clk_en. Output: ready.
- Decode and register file stay in the top.

## Test plan
- Reset: assert rst 2 clk, then check ready=1, all vol=F, tone0..2=0, ctrl3=0.
- Tone write: latch 0x8A, wait ready, then data 0x3F.
  - tone0 = 10'h3FA.
  - ready low for exactly 32 clk_en ticks after each write.
- Noise: latch 0xE5.
  - ctrl3 = 3'b101.
  - clr high for exactly 1 clk, the clk after acceptance.
  - Then data byte 0x02: ctrl3 = 3'b010 and a second clr pulse.
- Volume: latch 0xD3 then data 0x07.
  - vol2 goes 3 then 7.
  - Latch index stays 5, so a further data 0x0C gives vol2 = C.
- Busy rejection:
  - A write of 0x9F pulsed while ready==0 leaves vol0 = F.
  - wr_n held low across end of busy causes no write.
- Reset mid-busy: accept 0x81, assert rst 5 clk_en ticks later.
  - Next clk: ready=1, tone0=0.
  - A new write is accepted at once.
